// File: rtl/emissor_voto.sv
// Ballot transmitter: queues candidate requests and sends each as two strobed 4-bit digits.
// It then checks the returned status, and finally raises the sticky close-of-poll line.
module emissor_voto #(
  parameter int QDEPTH      = 4,
  parameter int HOLD_CYC    = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [1:0] req_cand,
  output logic       req_ready,
  input  logic       close_req,
  output logic [3:0] digito,
  output logic       valid_out,
  output logic       finish_out,
  input  logic       status_vld,
  input  logic       status_in,
  output logic       busy,
  output logic [7:0] sent_count,
  output logic [7:0] mismatch_count,
  output logic       timeout_err
);
  localparam int AW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CMAX = (HOLD_CYC > ACK_TIMEOUT) ? HOLD_CYC : ACK_TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(QDEPTH);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(CMAX);

  typedef enum logic [2:0] {
    IDLE, D1_HOLD, D1_STB, D2_HOLD, D2_STB, WAIT_ACK, CLOSE, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] tcnt_q, tcnt_d;
  logic [1:0]    mem_q [QDEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   fill_q;
  logic [1:0]    cur_q;
  logic          closing_q;
  logic [3:0]    digito_q, digit_d;
  logic          valid_q, finish_q, busy_q, tmo_q;
  logic [7:0]    sent_q, mism_q;
  logic          push, pop, full, empty, ack, tmo_evt, exp_status;

  function automatic logic [3:0] digit_of(input logic [1:0] cand, input logic second);
    if (cand[1])      return 4'b0000;
    else if (cand[0]) return 4'b0010;
    else              return second ? 4'b0011 : 4'b0001;
  endfunction

  assign full       = (fill_q == FULL_CNT);
  assign empty      = (fill_q == '0);
  assign req_ready  = !full && !closing_q && (state_q != DONE);
  assign push       = req_valid && req_ready;
  assign exp_status = ~cur_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   fill_q <= fill_q + 1'b1;
        2'b01:   fill_q <= fill_q - 1'b1;
        default: fill_q <= fill_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= req_cand;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    ack     = 1'b0;
    tmo_evt = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = D1_HOLD;
        end else if (closing_q) begin
          state_d = CLOSE;
        end
      end
      D1_HOLD:  if (tcnt_q == HOLD_LAST) state_d = D1_STB;
      D1_STB:   state_d = D2_HOLD;
      D2_HOLD:  if (tcnt_q == HOLD_LAST) state_d = D2_STB;
      D2_STB:   state_d = WAIT_ACK;
      WAIT_ACK: begin
        if (status_vld) begin
          ack     = 1'b1;
          state_d = IDLE;
        end else if (tcnt_q == ACK_LAST) begin
          tmo_evt = 1'b1;
          state_d = IDLE;
        end
      end
      CLOSE:    state_d = DONE;
      DONE:     state_d = DONE;
      default:  state_d = IDLE;
    endcase
  end

  // One counter serves both hold and ack windows; it restarts on every state change.
  always_comb begin
    tcnt_d = tcnt_q;
    if (state_d != state_q)   tcnt_d = '0;
    else if (tcnt_q != CNT_MAX) tcnt_d = tcnt_q + 1'b1;
  end

  always_comb begin
    digit_d = 4'b0000;
    case (state_q)
      D1_HOLD, D1_STB: digit_d = digit_of(cur_q, 1'b0);
      D2_HOLD, D2_STB: digit_d = digit_of(cur_q, 1'b1);
      default:         digit_d = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tcnt_q    <= '0;
      cur_q     <= '0;
      closing_q <= 1'b0;
      digito_q  <= '0;
      valid_q   <= 1'b0;
      finish_q  <= 1'b0;
      busy_q    <= 1'b0;
      sent_q    <= '0;
      mism_q    <= '0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      if (pop) cur_q <= mem_q[rd_ptr_q];
      closing_q <= closing_q | (close_req && (state_q != DONE));
      digito_q  <= digit_d;
      valid_q   <= (state_q == D1_STB) || (state_q == D2_STB);
      finish_q  <= finish_q | (state_q == CLOSE);
      busy_q    <= !((state_d == IDLE) || (state_d == DONE));
      if (ack && (sent_q != 8'hFF)) sent_q <= sent_q + 8'd1;
      if (ack && (status_in != exp_status) && (mism_q != 8'hFF)) mism_q <= mism_q + 8'd1;
      tmo_q     <= tmo_q | tmo_evt;
    end
  end

  assign digito         = digito_q;
  assign valid_out      = valid_q;
  assign finish_out     = finish_q;
  assign busy           = busy_q;
  assign sent_count     = sent_q;
  assign mismatch_count = mism_q;
  assign timeout_err    = tmo_q;
endmodule
